// File: rtl/prog_loader.sv
// Boot loader: parses header/payload word stream into instruction and data BRAM writes, then releases the CPU.
// Latency: write pulse one cycle after each accepted payload word; done/err flags registered after the state change.
// Backpressure: s_ready low in reset, DONE and ERR; gaps in s_valid simply pause. Optional checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  pc_stall,
  output logic                  d_bram_init_done,
  output logic                  load_done,
  output logic                  load_err,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    LOAD = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_nxt;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_err;
  logic                  r_tgt;
  logic                  r_last;
  logic [15:0]           r_count;
  logic [15:0]           r_idx;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [ADDR_WIDTH-1:0] r_i_addr;
  logic [ADDR_WIDTH-1:0] r_d_addr;
  logic [DATA_WIDTH-1:0] r_i_dat;
  logic [DATA_WIDTH-1:0] r_d_dat;
  logic                  r_i_enb;
  logic                  r_d_enb;
  logic [15:0]           r_words;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]           r_sum;
`endif

  logic       w_acc;
  logic       w_hdr_bad;
  logic       w_last_word;
  state_t     w_sec_end;

  assign w_acc       = s_valid & r_ready;
  assign w_hdr_bad   = (s_dat[29:16] != 14'd0) || (s_dat[15:0] > 16'(MAX_WORDS));
  assign w_last_word = (r_idx == r_count - 16'd1);
  // Where a section goes once its payload (and checksum, if any) is consumed.
  assign w_sec_end   = r_last ? DONE : HDR;

  // Next-state decode for the header/payload/checksum protocol.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      HDR: begin
        if (w_acc) begin
          if (w_hdr_bad) begin
            w_nxt = ERR;
          end else if (s_dat[15:0] == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            w_nxt = CSUM;
`else
            w_nxt = s_dat[31] ? DONE : HDR;
`endif
          end else begin
            w_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (w_acc && w_last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          w_nxt = CSUM;
`else
          w_nxt = w_sec_end;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        // Checksum word is the bitwise inverse of the wrapping payload sum.
        if (w_acc) begin
          w_nxt = (s_dat[31:0] == ~r_sum) ? w_sec_end : ERR;
        end
      end
`endif
      DONE:    w_nxt = DONE;
      ERR:     w_nxt = ERR;
      default: w_nxt = ERR;
    endcase
  end

  // State, handshake, header latches, write-port registers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= HDR;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_tgt    <= 1'b0;
      r_last   <= 1'b0;
      r_count  <= 16'd0;
      r_idx    <= 16'd0;
      r_waddr  <= '0;
      r_i_addr <= '0;
      r_d_addr <= '0;
      r_i_dat  <= '0;
      r_d_dat  <= '0;
      r_i_enb  <= 1'b0;
      r_d_enb  <= 1'b0;
      r_words  <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum    <= 32'd0;
`endif
    end else begin
      r_state <= w_nxt;
      r_ready <= (w_nxt == HDR) || (w_nxt == LOAD) || (w_nxt == CSUM);
      r_err   <= (w_nxt == ERR);
      // Done trails entry into DONE by a cycle so it lands after the final write pulse.
      r_done  <= (r_state == DONE);
      r_i_enb <= 1'b0;
      r_d_enb <= 1'b0;
      if (w_acc && r_state == HDR) begin
        r_last  <= s_dat[31];
        r_tgt   <= s_dat[30];
        r_count <= s_dat[15:0];
        r_idx   <= 16'd0;
        r_waddr <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        r_sum   <= 32'd0;
`endif
      end
      if (w_acc && r_state == LOAD) begin
        r_idx   <= r_idx + 16'd1;
        r_waddr <= r_waddr + ADDR_WIDTH'(4);
        r_words <= r_words + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
        r_sum   <= r_sum + s_dat[31:0];
`endif
        if (r_tgt) begin
          r_d_enb  <= 1'b1;
          r_d_addr <= r_waddr;
          r_d_dat  <= s_dat;
        end else begin
          r_i_enb  <= 1'b1;
          r_i_addr <= r_waddr;
          r_i_dat  <= s_dat;
        end
      end
    end
  end

  assign s_ready          = r_ready;
  assign i_w_addr         = r_i_addr;
  assign i_w_dat          = r_i_dat;
  assign i_w_enb          = r_i_enb;
  assign d_w_addr         = r_d_addr;
  assign d_w_dat          = r_d_dat;
  // Once the core owns the data BRAM the loader must never write it.
  assign d_w_enb          = r_d_enb & ~r_done;
  assign pc_stall         = ~r_done;
  assign d_bram_init_done = r_done;
  assign load_done        = r_done;
  assign load_err         = r_err;
  assign words_loaded     = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: basic load, gapped stream, errors, mid-load reset, empty section, post-load idle.
// Inputs change 1ns after the rising edge; outputs are sampled there or on the falling edge.
// Write pulses are captured on the falling edge into a queue and compared against hand-computed lists.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_dat = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [9:0]  i_w_addr;
  logic [31:0] i_w_dat;
  logic        i_w_enb;
  logic [9:0]  d_w_addr;
  logic [31:0] d_w_dat;
  logic        d_w_enb;
  logic        pc_stall;
  logic        d_bram_init_done;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        tgt;
    logic [9:0]  addr;
    logic [31:0] dat;
  } wr_t;
  wr_t wq[$];

  // Expected write sequence of the basic stream.
  wr_t exp_wr [5];

  prog_loader dut (
    .clk(clk), .rst(rst), .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .pc_stall(pc_stall), .d_bram_init_done(d_bram_init_done),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Capture every write pulse.
  always @(negedge clk) begin
    if (i_w_enb) wq.push_back({1'b0, i_w_addr, i_w_dat});
    if (d_w_enb) wq.push_back({1'b1, d_w_addr, d_w_dat});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, wait (bounded) for s_ready, let it be accepted, optionally idle a cycle.
  task automatic put(input logic [31:0] w, input bit gap);
    int n = 0;
    s_dat   = w;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("put_timeout", 1, 0);
    tick();
    s_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_pc_stall", pc_stall, 1);
    chk("rst_status", {load_done, load_err, d_bram_init_done, i_w_enb, d_w_enb}, 0);
    chk("rst_words", words_loaded, 0);
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", s_ready, 1);
    wq.delete();
  endtask

  task automatic send_basic(input bit gap);
    put(32'h0000_0003, gap);
    put(32'h0050_0293, gap);
    put(32'h0030_0313, gap);
    put(32'h0000_006f, gap);
`ifdef PROG_LOADER_CHECKSUM_EN
    put(32'hFF7F_F9EA, gap);
`endif
    put(32'hC000_0002, gap);
    put(32'h0000_0004, gap);
    put(32'h0000_0003, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    put(32'hFFFF_FFF8, 1'b0);
`endif
  endtask

  task automatic check_basic(input string tag);
    chk({tag, "_done_late"}, load_done, 0);
`ifndef PROG_LOADER_CHECKSUM_EN
    chk({tag, "_last_pulse"}, d_w_enb, 1);
`endif
    tick();
    chk({tag, "_done"}, {load_done, d_bram_init_done, pc_stall}, 3'b110);
    chk({tag, "_words"}, words_loaded, 5);
    chk({tag, "_rdy_low"}, s_ready, 0);
    chk({tag, "_nwr"}, wq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wq.size()) chk({tag, "_wr"}, wq[i], exp_wr[i]);
    end
  endtask

  initial begin
    int bad_cycles;
    exp_wr[0] = {1'b0, 10'h000, 32'h0050_0293};
    exp_wr[1] = {1'b0, 10'h004, 32'h0030_0313};
    exp_wr[2] = {1'b0, 10'h008, 32'h0000_006f};
    exp_wr[3] = {1'b1, 10'h000, 32'h0000_0004};
    exp_wr[4] = {1'b1, 10'h004, 32'h0000_0003};

    // Basic back-to-back load.
    do_reset();
    send_basic(1'b0);
    check_basic("basic");

    // Post-load: words offered for 100 cycles are refused, nothing moves.
    s_dat = 32'hDEAD_BEEF;
    s_valid = 1'b1;
    bad_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (s_ready || i_w_enb || d_w_enb || !load_done || pc_stall || load_err ||
          words_loaded != 16'd5) bad_cycles++;
    end
    s_valid = 1'b0;
    chk("post_stable", bad_cycles, 0);
    chk("post_nwr", wq.size(), 5);

    // Same stream with s_valid low on alternate cycles.
    do_reset();
    send_basic(1'b1);
    check_basic("gaps");

    // Reset after two of three instruction words, then full reload.
    do_reset();
    put(32'h0000_0003, 1'b0);
    put(32'h0050_0293, 1'b0);
    put(32'h0030_0313, 1'b0);
    chk("mid_words", words_loaded, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_outs", {s_ready, i_w_enb, d_w_enb, load_done, load_err, pc_stall}, 6'b000001);
    chk("mid_rst_words", words_loaded, 0);
    rst = 1'b0;
    tick();
    wq.delete();
    send_basic(1'b0);
    check_basic("reload");

    // COUNT = MAX_WORDS + 1.
    do_reset();
    put(32'h0000_0101, 1'b0);
    chk("cnt_err", {load_err, s_ready, pc_stall}, 3'b101);
    s_dat = 32'h1234_5678;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    s_valid = 1'b0;
    chk("cnt_err_nwr", wq.size(), 0);
    chk("cnt_err_hold", {load_err, load_done, words_loaded}, {1'b1, 1'b0, 16'd0});

    // Reserved header bit.
    do_reset();
    put(32'h2000_0001, 1'b0);
    chk("rsv_err", {load_err, s_ready, pc_stall}, 3'b101);

    // COUNT = MAX_WORDS is legal: header leaves s_ready high and no error.
    do_reset();
    put(32'h0000_0100, 1'b0);
    chk("max_ok", {load_err, s_ready}, 2'b01);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum off by one.
    do_reset();
    put(32'h8000_0001, 1'b0);
    put(32'h0000_0005, 1'b0);
    put(32'hFFFF_FFFB, 1'b0);
    tick();
    chk("csum_err", {load_err, load_done, pc_stall}, 3'b101);
`endif

    // Empty final section.
    do_reset();
    put(32'h8000_0000, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    put(32'hFFFF_FFFF, 1'b0);
`endif
    tick();
    chk("empty_done", {load_done, load_err, pc_stall}, 3'b100);
    chk("empty_words", words_loaded, 0);
    chk("empty_nwr", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
